// File: rtl/key_scan_if.sv
// Keypad-side bundle for key_scan: row sense in, column drive and
// debounced key reporting out.
interface key_scan_if;
    logic [3:0] row;
    logic [3:0] col;
    logic       key_valid;
    logic [3:0] key_code;
    logic       key_held;

    modport master (
        input  row,
        output col,
        output key_valid,
        output key_code,
        output key_held
    );

    modport slave (
        output row,
        input  col,
        input  key_valid,
        input  key_code,
        input  key_held
    );
endinterface

// File: rtl/key_scan.sv
// 4x4 matrix keypad scanner: walks a single low column, debounces the
// returned row pattern and reports one pulse per physical key press.
module key_scan #(
    parameter int SCAN_DIV  = 50000,
    parameter int DEB_TICKS = 10
) (
    input  logic       clk,
    input  logic       rst,
    key_scan_if.master kbd
);

    localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int CW = $clog2(DEB_TICKS + 1);
    localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);
    localparam logic [DW-1:0] DIV_ONE  = DW'(1);
    localparam logic [CW-1:0] DEB_LAST = CW'(DEB_TICKS - 1);
    localparam logic [CW-1:0] DEB_ONE  = CW'(1);

    typedef enum logic [1:0] {
        SCAN,
        DEBOUNCE,
        PRESSED,
        RELEASE
    } state_t;

    state_t        state_q;
    logic [3:0]    rowMeta_q;
    logic [3:0]    rowS_q;
    logic [DW-1:0] div_q;
    logic [DW-1:0] div_d;
    logic [3:0]    col_q;
    logic [3:0]    col_d;
    logic [1:0]    colIdx_q;
    logic [1:0]    colIdx_d;
    logic [CW-1:0] debCnt_q;
    logic [3:0]    pat_q;
    logic [1:0]    rowIdx_q;
    logic          keyValid_q;
    logic [3:0]    keyCode_q;
    logic          keyHeld_q;

    logic          tick;
    logic          single;
    logic [1:0]    rowIdx;
    logic          rowsIdle;

    // A key is only trusted when exactly one row is pulled low; two or more
    // low rows in one column can be ghosting, so they are treated as noise.
    always_comb begin
        single = 1'b0;
        rowIdx = 2'd0;
        case (rowS_q)
            4'b1110: begin single = 1'b1; rowIdx = 2'd0; end
            4'b1101: begin single = 1'b1; rowIdx = 2'd1; end
            4'b1011: begin single = 1'b1; rowIdx = 2'd2; end
            4'b0111: begin single = 1'b1; rowIdx = 2'd3; end
            default: begin single = 1'b0; rowIdx = 2'd0; end
        endcase
    end

    assign tick     = (div_q == DIV_LAST);
    assign div_d    = tick ? '0 : div_q + DIV_ONE;
    assign col_d    = {col_q[2:0], col_q[3]};
    assign colIdx_d = colIdx_q + 2'd1;
    assign rowsIdle = (rowS_q == 4'b1111);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= SCAN;
            rowMeta_q  <= 4'b1111;
            rowS_q     <= 4'b1111;
            div_q      <= '0;
            col_q      <= 4'b1110;
            colIdx_q   <= 2'd0;
            debCnt_q   <= '0;
            pat_q      <= 4'b1111;
            rowIdx_q   <= 2'd0;
            keyValid_q <= 1'b0;
            keyCode_q  <= 4'd0;
            keyHeld_q  <= 1'b0;
        end else begin
            rowMeta_q  <= kbd.row;
            rowS_q     <= rowMeta_q;
            div_q      <= div_d;
            keyValid_q <= 1'b0;

            if (tick) begin
                case (state_q)
                    SCAN: begin
                        if (single) begin
                            pat_q    <= rowS_q;
                            rowIdx_q <= rowIdx;
                            debCnt_q <= DEB_ONE;
                            if (DEB_TICKS == 1) begin
                                keyCode_q  <= {rowIdx, colIdx_q};
                                keyValid_q <= 1'b1;
                                keyHeld_q  <= 1'b1;
                                state_q    <= PRESSED;
                            end else begin
                                state_q <= DEBOUNCE;
                            end
                        end else begin
                            col_q    <= col_d;
                            colIdx_q <= colIdx_d;
                        end
                    end

                    DEBOUNCE: begin
                        if (rowS_q == pat_q) begin
                            debCnt_q <= debCnt_q + DEB_ONE;
                            if (debCnt_q == DEB_LAST) begin
                                keyCode_q  <= {rowIdx_q, colIdx_q};
                                keyValid_q <= 1'b1;
                                keyHeld_q  <= 1'b1;
                                state_q    <= PRESSED;
                            end
                        end else begin
                            debCnt_q <= '0;
                            col_q    <= col_d;
                            colIdx_q <= colIdx_d;
                            state_q  <= SCAN;
                        end
                    end

                    // Column stays parked on the held key so any other key is
                    // invisible until this one is fully released.
                    PRESSED: begin
                        if (rowsIdle) begin
                            if (DEB_TICKS == 1) begin
                                keyHeld_q <= 1'b0;
                                debCnt_q  <= '0;
                                col_q     <= col_d;
                                colIdx_q  <= colIdx_d;
                                state_q   <= SCAN;
                            end else begin
                                debCnt_q <= DEB_ONE;
                                state_q  <= RELEASE;
                            end
                        end
                    end

                    RELEASE: begin
                        if (rowsIdle) begin
                            if (debCnt_q == DEB_LAST) begin
                                keyHeld_q <= 1'b0;
                                debCnt_q  <= '0;
                                col_q     <= col_d;
                                colIdx_q  <= colIdx_d;
                                state_q   <= SCAN;
                            end else begin
                                debCnt_q <= debCnt_q + DEB_ONE;
                            end
                        end else begin
                            state_q <= PRESSED;
                        end
                    end

                    default: state_q <= SCAN;
                endcase
            end
        end
    end

    assign kbd.col       = col_q;
    assign kbd.key_valid = keyValid_q;
    assign kbd.key_code  = keyCode_q;
    assign kbd.key_held  = keyHeld_q;

endmodule

// File: tb/tb_key_scan.sv
// Scoreboard bench for key_scan: a keypad model closes row r onto column c,
// directed presses queue their expected codes, a monitor checks each pulse.
module tb_key_scan;

    localparam int SD = 4;
    localparam int DT = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] keysDown = 16'h0000;
    logic [3:0]  rowDrive;
    logic [3:0]  monExp;
    logic [3:0]  expCol;
    int          cyc = 0;
    int          compared = 0;
    int          mismatched = 0;
    logic [3:0]  expQ[$];

    always #5 clk = ~clk;

    key_scan_if kbd ();

    key_scan #(
        .SCAN_DIV (SD),
        .DEB_TICKS(DT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .kbd(kbd)
    );

    // Keypad matrix: a closed switch pulls its row low while its column is driven low.
    always_comb begin
        rowDrive = 4'b1111;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (keysDown[r*4+c] && !kbd.col[c]) rowDrive[r] = 1'b0;
    end
    assign kbd.row = rowDrive;

    // Clocks since reset release; a multiple of SD marks a scan tick edge.
    always @(posedge clk) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    // Every key_valid pulse must match the oldest queued expected code.
    always @(negedge clk) begin
        if (kbd.key_valid === 1'b1) begin
            compared++;
            if (expQ.size() == 0) begin
                mismatched++;
                $display("[TB] FAIL pulse: unexpected key_valid with code %0h, none expected", kbd.key_code);
            end else begin
                monExp = expQ.pop_front();
                if (kbd.key_code !== monExp) begin
                    mismatched++;
                    $display("[TB] FAIL pulse code: got %0h expected %0h", kbd.key_code, monExp);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic [15:0] keys);
        keysDown = keys;
    endtask

    task automatic waitTick();
        do @(negedge clk); while (cyc % SD != 0);
    endtask

    task automatic waitCol(input logic [3:0] target);
        int n;
        n = 0;
        waitTick();
        while (kbd.col !== target && n < 12) begin
            waitTick();
            n++;
        end
        checkOutput("reach col", kbd.col, target);
    endtask

    task automatic waitHeld(input logic lvl, input string name);
        int n;
        n = 0;
        while (kbd.key_held !== lvl && n < 40) begin
            waitTick();
            n++;
        end
        checkOutput(name, kbd.key_held, lvl);
    endtask

    task automatic doReset();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("reset col", kbd.col, 4'b1110);
        checkOutput("reset held", kbd.key_held, 1'b0);
        checkOutput("reset code", kbd.key_code, 4'h0);
        checkOutput("reset valid", kbd.key_valid, 1'b0);
    endtask

    initial begin
        logic [3:0] prevCol;

        // Idle scan: one column step every SD clocks
        doReset();
        for (int i = 1; i <= 16; i++) begin
            @(negedge clk);
            expCol = ~(4'b0001 << ((i / 4) % 4));
            checkOutput("idle col", kbd.col, expCol);
        end
        checkOutput("idle held", kbd.key_held, 1'b0);

        // Key r2,c1 held, then clean release resumes from the next column
        waitCol(4'b1101);
        expQ.push_back(4'b1001);
        applyStimulus(16'h0200);
        waitHeld(1'b1, "key9 held rise");
        for (int k = 0; k < 4; k++) begin
            waitTick();
            checkOutput("key9 col frozen", kbd.col, 4'b1101);
            checkOutput("key9 still held", kbd.key_held, 1'b1);
        end
        applyStimulus(16'h0000);
        waitTick();
        checkOutput("key9 release t1", kbd.key_held, 1'b1);
        waitTick();
        checkOutput("key9 release t2", kbd.key_held, 1'b1);
        waitTick();
        checkOutput("key9 release t3", kbd.key_held, 1'b0);
        checkOutput("key9 resume col", kbd.col, 4'b1011);

        // Key r0,c3 opens on the second tick: debounce aborts, scan restarts
        waitCol(4'b0111);
        applyStimulus(16'h0008);
        waitTick();
        checkOutput("bounce capture col", kbd.col, 4'b0111);
        applyStimulus(16'h0000);
        waitTick();
        checkOutput("bounce restart col", kbd.col, 4'b1110);
        checkOutput("bounce no held", kbd.key_held, 1'b0);
        expQ.push_back(4'b0011);
        applyStimulus(16'h0008);
        waitHeld(1'b1, "key3 held rise");
        checkOutput("key3 code", kbd.key_code, 4'b0011);

        // Release that bounces back closed keeps the key held
        applyStimulus(16'h0000);
        waitTick();
        checkOutput("rel bounce t1 held", kbd.key_held, 1'b1);
        applyStimulus(16'h0008);
        waitTick();
        checkOutput("rel bounce t2 held", kbd.key_held, 1'b1);
        checkOutput("rel bounce col", kbd.col, 4'b0111);
        applyStimulus(16'h0000);
        waitTick();
        waitTick();
        checkOutput("key3 release t2", kbd.key_held, 1'b1);
        waitTick();
        checkOutput("key3 release t3", kbd.key_held, 1'b0);
        checkOutput("key3 resume col", kbd.col, 4'b1110);

        // Ghosting: r1 and r3 both low in column 0 never capture
        waitCol(4'b1110);
        applyStimulus(16'h1010);
        prevCol = 4'b1110;
        for (int k = 0; k < 8; k++) begin
            waitTick();
            expCol = {prevCol[2:0], prevCol[3]};
            checkOutput("ghost col advance", kbd.col, expCol);
            prevCol = expCol;
        end
        checkOutput("ghost no held", kbd.key_held, 1'b0);

        // Long hold of key 15 gives exactly one pulse
        applyStimulus(16'h0000);
        expQ.push_back(4'b1111);
        applyStimulus(16'h8000);
        waitHeld(1'b1, "key15 held rise");
        for (int k = 0; k < 6; k++) begin
            waitTick();
            checkOutput("key15 held", kbd.key_held, 1'b1);
            checkOutput("key15 col", kbd.col, 4'b0111);
        end
        applyStimulus(16'h0000);
        waitTick();
        waitTick();
        waitTick();
        checkOutput("key15 released", kbd.key_held, 1'b0);

        // Reset while debouncing
        waitCol(4'b1101);
        applyStimulus(16'h0200);
        waitTick();
        checkOutput("deb capture col", kbd.col, 4'b1101);
        applyStimulus(16'h0000);
        doReset();
        for (int k = 0; k < 4; k++) waitTick();
        checkOutput("after deb reset held", kbd.key_held, 1'b0);

        // Reset while a key is held
        expQ.push_back(4'b0110);
        applyStimulus(16'h0040);
        waitHeld(1'b1, "key6 held rise");
        waitTick();
        applyStimulus(16'h0000);
        doReset();
        for (int k = 0; k < 8; k++) waitTick();
        checkOutput("after held reset held", kbd.key_held, 1'b0);

        checkOutput("pending pulses", expQ.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
